// File: rtl/axis_acc_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | axis_acc_pkg: shared types and sign/magnitude helpers for the add/sub |
// | accumulator path.                        Revision: 1.0               |
// +-----------------------------------------------------------------------+
package axis_acc_pkg;

  localparam int C_MAX_W     = 64;
  localparam int C_DEFAULT_W = 16;

  typedef struct packed {
    logic [C_DEFAULT_W-1:0] data;
    logic                   last;
  } slot_t;

  // Helpers operate on zero-extended values so any width up to C_MAX_W can share them.
  function automatic logic is_neg(input logic [C_MAX_W-1:0] value, input int width);
    return |(value & (C_MAX_W'(1) << (width - 1)));
  endfunction

  function automatic logic [C_MAX_W-1:0] magnitude(input logic [C_MAX_W-1:0] value,
                                                   input int width);
    logic [C_MAX_W-1:0] mask;
    mask = (width >= C_MAX_W) ? '1 : ((C_MAX_W'(1) << width) - C_MAX_W'(1));
    return is_neg(value, width) ? ((~value + C_MAX_W'(1)) & mask) : (value & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_out_slot.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | axis_out_slot: single-entry registered AXI-Stream output slot.        |
// |                                          Revision: 1.0               |
// +-----------------------------------------------------------------------+
module axis_out_slot
  import axis_acc_pkg::*;
#(
  parameter type T_ENTRY = slot_t
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   i_load,
  input  T_ENTRY i_entry,
  input  logic   i_ready,
  output logic   o_valid,
  output T_ENTRY o_entry,
  output logic   o_free
);

  logic   r_valid;
  T_ENTRY r_entry;

  assign o_free  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_entry = r_entry;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_entry <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_entry <= i_entry;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_sign_splitter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | axis_sign_splitter: steers signed beats to add (value) / sub          |
// | (magnitude) streams, closing every packet on both. Revision: 1.0      |
// +-----------------------------------------------------------------------+
module axis_sign_splitter
  import axis_acc_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [DATA_WIDTH-1:0]  s_tdata,
  input  logic                   s_tvalid,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic [DATA_WIDTH-1:0]  m_add_tdata,
  output logic                   m_add_tvalid,
  output logic                   m_add_tlast,
  input  logic                   m_add_tready,
  output logic [DATA_WIDTH-1:0]  m_sub_tdata,
  output logic                   m_sub_tvalid,
  output logic                   m_sub_tlast,
  input  logic                   m_sub_tready,
  output logic                   stat_valid,
  output logic [COUNT_WIDTH-1:0] stat_add_cnt,
  output logic [COUNT_WIDTH-1:0] stat_sub_cnt
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } entry_t;

  logic                   r_run;
  logic [COUNT_WIDTH-1:0] r_add_cnt;
  logic [COUNT_WIDTH-1:0] r_sub_cnt;
  logic                   r_stat_valid;
  logic [COUNT_WIDTH-1:0] r_stat_add;
  logic [COUNT_WIDTH-1:0] r_stat_sub;

  logic                   w_add_free, w_sub_free;
  logic                   w_accept, w_neg;
  logic [DATA_WIDTH-1:0]  w_mag;
  logic                   w_add_load, w_sub_load;
  entry_t                 w_add_in, w_sub_in, w_add_out, w_sub_out;
  logic [COUNT_WIDTH-1:0] w_add_next, w_sub_next;

  // r_run keeps s_tready low while resetn is asserted, even though the slots are free.
  assign s_tready = r_run && w_add_free && w_sub_free;
  assign w_accept = s_tvalid && s_tready;
  assign w_neg    = is_neg(C_MAX_W'(s_tdata), DATA_WIDTH);
  assign w_mag    = DATA_WIDTH'(magnitude(C_MAX_W'(s_tdata), DATA_WIDTH));

  // The stream not targeted by a last beat receives a zero terminator.
  assign w_add_load    = w_accept && (!w_neg || s_tlast);
  assign w_sub_load    = w_accept && (w_neg || s_tlast);
  assign w_add_in.data = w_neg ? '0 : s_tdata;
  assign w_add_in.last = s_tlast;
  assign w_sub_in.data = w_neg ? w_mag : '0;
  assign w_sub_in.last = s_tlast;

  axis_out_slot #(.T_ENTRY(entry_t)) u_add_slot (
    .clk     (clk),
    .resetn  (resetn),
    .i_load  (w_add_load),
    .i_entry (w_add_in),
    .i_ready (m_add_tready),
    .o_valid (m_add_tvalid),
    .o_entry (w_add_out),
    .o_free  (w_add_free)
  );

  axis_out_slot #(.T_ENTRY(entry_t)) u_sub_slot (
    .clk     (clk),
    .resetn  (resetn),
    .i_load  (w_sub_load),
    .i_entry (w_sub_in),
    .i_ready (m_sub_tready),
    .o_valid (m_sub_tvalid),
    .o_entry (w_sub_out),
    .o_free  (w_sub_free)
  );

  assign m_add_tdata = w_add_out.data;
  assign m_add_tlast = w_add_out.last;
  assign m_sub_tdata = w_sub_out.data;
  assign m_sub_tlast = w_sub_out.last;

  assign w_add_next = (w_accept && !w_neg && (r_add_cnt != '1))
                      ? r_add_cnt + COUNT_WIDTH'(1) : r_add_cnt;
  assign w_sub_next = (w_accept && w_neg && (r_sub_cnt != '1))
                      ? r_sub_cnt + COUNT_WIDTH'(1) : r_sub_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_run        <= 1'b0;
      r_add_cnt    <= '0;
      r_sub_cnt    <= '0;
      r_stat_valid <= 1'b0;
      r_stat_add   <= '0;
      r_stat_sub   <= '0;
    end else begin
      r_run        <= 1'b1;
      r_stat_valid <= 1'b0;
      if (w_accept && s_tlast) begin
        r_stat_valid <= 1'b1;
        r_stat_add   <= w_add_next;
        r_stat_sub   <= w_sub_next;
        r_add_cnt    <= '0;
        r_sub_cnt    <= '0;
      end else begin
        r_add_cnt    <= w_add_next;
        r_sub_cnt    <= w_sub_next;
      end
    end
  end

  assign stat_valid   = r_stat_valid;
  assign stat_add_cnt = r_stat_add;
  assign stat_sub_cnt = r_stat_sub;

endmodule
`default_nettype wire

// File: doc/axis_sign_splitter.md
Name: axis_sign_splitter

Overview:
Upstream feeder for the add/sub accumulator stage. It takes one signed AXI-Stream packet stream and steers each beat to one of two output streams. Non-negative values go to the add stream unchanged. Negative values go to the sub stream as their magnitude. Every input packet ends with exactly one tlast beat on both outputs, so the downstream accumulator can close its packet and produce sum(add) - sum(sub), which equals the original signed sum.

Parameters:
- DATA_WIDTH, 16, width of all tdata buses; input is two's complement, outputs are unsigned.
- COUNT_WIDTH, 8, width of the per-packet beat counters and status outputs.

Ports:
- clk  in  1  clock
- resetn  in  1  reset (asynchronous, active-low)
- s_tdata  in  DATA_WIDTH  signed input sample
- s_tvalid  in  1  input valid
- s_tlast  in  1  last beat of input packet
- s_tready  out  1  input ready
- m_add_tdata  out  DATA_WIDTH  non-negative value
- m_add_tvalid  out  1  add stream valid
- m_add_tlast  out  1  add stream packet end
- m_add_tready  in  1  add stream ready
- m_sub_tdata  out  DATA_WIDTH  magnitude of negative value
- m_sub_tvalid  out  1  sub stream valid
- m_sub_tlast  out  1  sub stream packet end
- m_sub_tready  in  1  sub stream ready
- stat_valid  out  1  one-cycle pulse: packet fully accepted
- stat_add_cnt  out  COUNT_WIDTH  data beats routed to add in the last packet
- stat_sub_cnt  out  COUNT_WIDTH  data beats routed to sub in the last packet

Behaviour:
- Reset values: all outputs 0, including s_tready, counters and status. Reset mid-packet discards any held beats; no tlast is emitted for the aborted packet.
- Output slots: each output has one register slot (valid, data, last). A slot is free when !valid || tready.
- Input ready: s_tready = add_free && sub_free. It never depends on s_tdata or s_tlast.
- Accept: s_tvalid && s_tready.
- Routing: s_tdata[MSB] = 0 routes to add with data = s_tdata. Zero goes to add. MSB = 1 routes to sub with data = -s_tdata, taken as unsigned DATA_WIDTH. The most negative value 0x8..0 therefore maps to magnitude 0x8..0.
- Latency: an accepted beat appears on its output in the next cycle. Throughput is 1 beat/cycle while both consumers hold tready high.
- Non-last beat: load the target slot with last = 0. The other slot keeps its contents.
- Last beat (s_tlast = 1):
  - Target slot loads the value with last = 1.
  - The other slot loads a terminator beat: data = 0, last = 1.
  - Both slots load in the same cycle; s_tready guarantees both are free.
- Slots are registered outputs. A slot clears valid on tready unless it is reloaded in the same cycle. Output data and last are stable while valid && !tready.
- Counters add_cnt and sub_cnt:
  - They increment on each accepted beat routed to their stream, including the last beat. Terminator beats do not count.
  - They saturate at 2^COUNT_WIDTH - 1.
- On an accepted last beat:
  - stat_add_cnt/stat_sub_cnt load the final counts, including that beat, in the next cycle.
  - stat_valid pulses high for one cycle.
  - Both counters clear to 0.
  - Status values hold until the next packet end.
- Back-to-back packets: the first beat of the next packet may be accepted as soon as both slots are free. No idle cycle is inserted.
- Single-beat packet: one data beat on its stream plus one terminator beat on the other, both with tlast set.

Decomposition:
- Shared package axis_acc_pkg:
  - A typedef for the slot record {data, last}.
  - A localparam function for sign and magnitude extraction, shared with the accumulator-side testbench models.
- Sub-module axis_out_slot: single-entry registered AXIS output with a free flag, instantiated twice (add and sub).

Test Plan:
- DATA_WIDTH = 8; packet [5, -3, 7(last)], both readies at 1 → add stream gets 5, 7(last). Sub stream gets 3, 0(last), with the terminator in the same cycle as 7. stat_add_cnt = 2, stat_sub_cnt = 1, stat_valid one pulse.
- Packet [-128(last)] → sub stream gets 0x80(last), add stream gets 0(last). Status counts are 0 and 1.
- Packet [0, 0(last)] → add stream gets 0, 0(last); sub stream gets 0(last) only. Counts are 2 and 0.
- m_sub_tready held at 0 for 4 cycles while input streams [-1, 2, ...] → s_tready = 0 throughout. m_sub_tdata holds 1 and stays valid. No beat is lost or duplicated after ready returns.
- Two back-to-back packets with both readies at 1 → no bubble on s_tready. Second packet's status replaces the first. Counters restart from 0.
- COUNT_WIDTH = 2 with 6 positive beats → stat_add_cnt saturates at 3. resetn asserted mid-packet → all valids, stat_* and s_tready read 0 immediately, without waiting for a clock edge.
